// File: rtl/mc_rsp_model.sv
// Memory-controller responder model: word RAM behind the MC load/store request
// interface, in-order load responses after a fixed idle latency, and request flow control.
module mc_rsp_model #(
    parameter int         AW      = 10,
    parameter int         LATENCY = 4,
    parameter int         QDEPTH  = 16,
    parameter logic [7:0] FP_ID   = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mc_req_ld,
    input  logic        mc_req_st,
    input  logic [47:0] mc_req_vadr,
    input  logic [63:0] mc_req_wrd_rdctl,
    output logic        mc_rd_rq_stall,
    output logic        mc_wr_rq_stall,
    output logic        mc_rsp_push,
    output logic [31:0] mc_rsp_rdctl,
    output logic [63:0] mc_rsp_data,
    input  logic        mc_rsp_stall,
    input  logic        inj_rd_stall,
    input  logic        inj_wr_stall,
    output logic [31:0] ld_cnt,
    output logic [31:0] st_cnt,
    output logic [2:0]  err
);

    // Stage 0 is the RAM read register, followed by LATENCY-2 delay stages.
    localparam int            DL       = LATENCY - 1;
    localparam int            QW       = $clog2(QDEPTH);
    localparam int            OW       = 8;
    localparam logic [OW-1:0] STALL_TH = OW'(QDEPTH + LATENCY - 4);

    typedef struct packed {
        logic [23:0] ctl;
        logic [63:0] data;
    } rsp_t;

    function automatic logic [OW-1:0] occupancy(input logic [DL-1:0] vld,
                                                input logic [QW:0]   fifo_n,
                                                input logic          out_vld);
        logic [OW-1:0] sum;
        sum = OW'(fifo_n) + OW'(out_vld);
        for (int k = 0; k < DL; k++) begin
            sum = sum + OW'(vld[k]);
        end
        return sum;
    endfunction

    function automatic logic over_threshold(input logic [OW-1:0] n);
        return n >= STALL_TH;
    endfunction

    logic [63:0]   ram [2**AW];
    logic [AW-1:0] idx;
    logic          misalign;
    logic          st_ok;

    rsp_t          dl_ent [DL];
    logic [DL-1:0] dl_vld;
    logic [DL-1:0] dl_adv;
    logic [DL-1:0] dl_in;
    logic          ld_drop;

    rsp_t          fifo_mem [QDEPTH];
    logic [QW:0]   wp;
    logic [QW:0]   rp;
    logic [QW:0]   fcnt;
    logic          fifo_full;
    logic          fifo_pop;
    logic          fifo_push;
    logic [OW-1:0] occ;

    assign idx       = mc_req_vadr[AW+2:3];
    assign misalign  = (mc_req_vadr[2:0] != 3'b000);
    assign st_ok     = reset_n && mc_req_st && !misalign;
    assign fcnt      = wp - rp;
    assign fifo_full = (fcnt == (QW+1)'(QDEPTH));
    assign fifo_pop  = (fcnt != '0) && !mc_rsp_stall;
    assign occ       = occupancy(dl_vld, fcnt, mc_rsp_push);

    // The delay line compresses when the FIFO is full, so entries wait in place
    // instead of being lost; only a load that finds every slot taken is dropped.
    always_comb begin
        logic nxt_ok;
        logic adv_k;
        nxt_ok = !fifo_full || fifo_pop;
        dl_adv = '0;
        for (int k = DL - 1; k >= 0; k--) begin
            adv_k     = dl_vld[k] && nxt_ok;
            dl_adv[k] = adv_k;
            nxt_ok    = !dl_vld[k] || adv_k;
        end
        dl_in    = '0;
        dl_in[0] = mc_req_ld && nxt_ok;
        for (int k = 1; k < DL; k++) begin
            dl_in[k] = dl_adv[k-1];
        end
        ld_drop   = mc_req_ld && !nxt_ok;
        fifo_push = dl_adv[DL-1];
    end

    // Request stage: RAM read/write at the sampling edge (read returns pre-store data)
    always_ff @(posedge clk) begin
        if (st_ok) begin
            ram[idx] <= mc_req_wrd_rdctl;
        end
        if (dl_in[0]) begin
            dl_ent[0] <= {mc_req_wrd_rdctl[23:0], ram[idx]};
        end
        for (int k = 1; k < DL; k++) begin
            if (dl_in[k]) begin
                dl_ent[k] <= dl_ent[k-1];
            end
        end
        if (fifo_push) begin
            fifo_mem[wp[QW-1:0]] <= dl_ent[DL-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_vld <= '0;
            wp     <= '0;
            rp     <= '0;
        end else begin
            for (int k = 0; k < DL; k++) begin
                dl_vld[k] <= (dl_vld[k] && !dl_adv[k]) || dl_in[k];
            end
            if (fifo_push) begin
                wp <= wp + (QW+1)'(1);
            end
            if (fifo_pop) begin
                rp <= rp + (QW+1)'(1);
            end
        end
    end

    // Output stage: popped FIFO entry is presented the cycle after the pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mc_rsp_push  <= 1'b0;
            mc_rsp_rdctl <= '0;
            mc_rsp_data  <= '0;
        end else begin
            mc_rsp_push <= fifo_pop;
            if (fifo_pop) begin
                mc_rsp_rdctl <= {FP_ID, fifo_mem[rp[QW-1:0]].ctl};
                mc_rsp_data  <= fifo_mem[rp[QW-1:0]].data;
            end
        end
    end

    // The threshold leaves room for the loads still in flight from a requester
    // that samples the stall through its own register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mc_rd_rq_stall <= 1'b1;
            mc_wr_rq_stall <= 1'b1;
            ld_cnt         <= '0;
            st_cnt         <= '0;
            err            <= '0;
        end else begin
            mc_rd_rq_stall <= over_threshold(occ) || inj_rd_stall;
            mc_wr_rq_stall <= inj_wr_stall;
            ld_cnt         <= ld_cnt + 32'(mc_req_ld);
            st_cnt         <= st_cnt + 32'(st_ok);
            err            <= err | {mc_req_ld && mc_req_st,
                                     ld_drop,
                                     (mc_req_ld || mc_req_st) && misalign};
        end
    end

endmodule
